// File: rtl/alpha_sequencer_pkg.sv
// Shared types and constants for the alpha recursion sequencer.
// Holds the FSM state encoding and the initial alpha metric words.
package alpha_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_t;

   // State 0 starts at 0.0, every other state at -10000.0
   localparam logic [31:0] ALPHA_INIT_ZERO   = 32'h0000_0000;
   localparam logic [31:0] ALPHA_INIT_NEG    = 32'hC61C_4000;
   localparam logic [63:0] ALPHA_INIT_NEG_DP =
      64'hC0C3_8800_0000_0000;

endpackage

// File: rtl/alpha_sequencer.sv
// Alpha sequencer: walks one trellis block through an external
// alpha_element, one step outstanding at a time, and streams every
// alpha vector (init vector + one per step) into alpha storage.
// Ports:
//   clk, reset                  clock, async active-high reset
//   start                       block request (ignored while busy)
//   bm_valid/bm_ready/bm_data   branch-metric input handshake
//   ae_in_valid, ae_branch_metric, ae_previous_alpha  -> element
//   ae_out_valid, ae_alpha_metric                     <- element
//   alpha_wr_en/addr/data       alpha storage write port
//   busy, done, err             status (err is sticky)
module alpha_sequencer
   import alpha_sequencer_pkg::*;
#(
   parameter int BITS           = 32,
   parameter     PRECISION      = "SINGLE",
   parameter int STATES         = 4,
   parameter int OUTPUT_SYMBOLS = 4,
   parameter int BLOCK_LEN      = 64,
   localparam int AW = $clog2(BLOCK_LEN + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     bm_valid,
   output logic                     bm_ready,
   input  logic [OUTPUT_SYMBOLS-1:0]
                [BITS-1:0]          bm_data,
   output logic                     ae_in_valid,
   output logic [OUTPUT_SYMBOLS-1:0]
                [BITS-1:0]          ae_branch_metric,
   output logic [STATES-1:0]
                [BITS-1:0]          ae_previous_alpha,
   input  logic                     ae_out_valid,
   input  logic [STATES-1:0]
                [BITS-1:0]          ae_alpha_metric,
   output logic                     alpha_wr_en,
   output logic [AW-1:0]            alpha_wr_addr,
   output logic [STATES-1:0]
                [BITS-1:0]          alpha_wr_data,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   // Only the -10000.0 word depends on the number format
   localparam logic [BITS-1:0] NEG_WORD =
      (PRECISION == "DOUBLE") ?
      BITS'(ALPHA_INIT_NEG_DP) :
      BITS'(ALPHA_INIT_NEG);

   typedef logic [STATES-1:0][BITS-1:0] avec_t;
   typedef logic [OUTPUT_SYMBOLS-1:0][BITS-1:0] bvec_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [AW-1:0]   r_k;
   avec_t           r_prev;
   avec_t           w_init;
   logic            w_bm_fire;
   logic            w_capture;
   logic            w_stray;
   logic            w_last;

   logic            r_ae_in_valid;
   bvec_t           r_ae_bm;
   avec_t           r_ae_prev;
   logic            r_wr_en;
   logic [AW-1:0]   r_wr_addr;
   avec_t           r_wr_data;
   logic            r_err;

   always_comb begin
      for (int s = 0; s < STATES; s++) begin
         w_init[s] = (s == 0) ?
            BITS'(ALPHA_INIT_ZERO) : NEG_WORD;
      end
   end

   assign w_bm_fire = (r_state == ST_ISSUE) && bm_valid;
   assign w_capture = (r_state == ST_WAIT) && ae_out_valid;
   // Any result arriving when nothing is outstanding is a
   // protocol violation (includes results of abandoned blocks)
   assign w_stray   = (r_state != ST_WAIT) && ae_out_valid;
   assign w_last    = (r_k + AW'(1)) == AW'(BLOCK_LEN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_IDLE:  if (start) w_state_next = ST_INIT;
         ST_INIT:  w_state_next = ST_ISSUE;
         ST_ISSUE: if (bm_valid) w_state_next = ST_WAIT;
         ST_WAIT: begin
            if (ae_out_valid)
               w_state_next = w_last ? ST_DONE : ST_ISSUE;
         end
         ST_DONE:  w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_k           <= '0;
         r_prev        <= '0;
         r_ae_in_valid <= 1'b0;
         r_ae_bm       <= '0;
         r_ae_prev     <= '0;
         r_wr_en       <= 1'b0;
         r_wr_addr     <= '0;
         r_wr_data     <= '0;
         r_err         <= 1'b0;
      end else begin
         // Element inputs are zero except in the issue cycle
         r_ae_in_valid <= 1'b0;
         r_ae_bm       <= '0;
         r_ae_prev     <= '0;
         r_wr_en       <= 1'b0;
         if (r_state == ST_INIT) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= '0;
            r_wr_data <= w_init;
            r_prev    <= w_init;
            r_k       <= '0;
         end
         if (w_bm_fire) begin
            r_ae_in_valid <= 1'b1;
            r_ae_bm       <= bm_data;
            r_ae_prev     <= r_prev;
         end
         if (w_capture) begin
            r_prev    <= ae_alpha_metric;
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_k + AW'(1);
            r_wr_data <= ae_alpha_metric;
            r_k       <= r_k + AW'(1);
         end
         if (w_stray) r_err <= 1'b1;
      end
   end

   assign bm_ready          = (r_state == ST_ISSUE);
   assign busy              = (r_state != ST_IDLE);
   assign done              = (r_state == ST_DONE);
   assign ae_in_valid       = r_ae_in_valid;
   assign ae_branch_metric  = r_ae_bm;
   assign ae_previous_alpha = r_ae_prev;
   assign alpha_wr_en       = r_wr_en;
   assign alpha_wr_addr     = r_wr_addr;
   assign alpha_wr_data     = r_wr_data;
   assign err               = r_err;

endmodule

// File: tb/tb_alpha_sequencer.sv
// Self-checking bench for alpha_sequencer with a stub alpha element
// of programmable latency (result = previousAlpha ^ branch metric).
module tb_alpha_sequencer;
   import alpha_sequencer_pkg::*;

   localparam int BITS = 32;
   localparam int ST   = 4;
   localparam int OS   = 4;
   localparam int BL   = 4;
   localparam int AW   = $clog2(BL + 1);

   typedef logic [ST-1:0][BITS-1:0] avec_t;
   typedef logic [OS-1:0][BITS-1:0] bvec_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          bm_valid = 1'b0;
   bvec_t         bm_data = '0;
   logic          bm_ready;
   logic          ae_in_valid;
   bvec_t         ae_branch_metric;
   avec_t         ae_previous_alpha;
   logic          ae_out_valid = 1'b0;
   avec_t         ae_alpha_metric = '0;
   logic          alpha_wr_en;
   logic [AW-1:0] alpha_wr_addr;
   avec_t         alpha_wr_data;
   logic          busy;
   logic          done;
   logic          err;

   always #5 clk = ~clk;

   alpha_sequencer #(
      .BITS(BITS), .PRECISION("SINGLE"), .STATES(ST),
      .OUTPUT_SYMBOLS(OS), .BLOCK_LEN(BL)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .bm_valid(bm_valid), .bm_ready(bm_ready),
      .bm_data(bm_data),
      .ae_in_valid(ae_in_valid),
      .ae_branch_metric(ae_branch_metric),
      .ae_previous_alpha(ae_previous_alpha),
      .ae_out_valid(ae_out_valid),
      .ae_alpha_metric(ae_alpha_metric),
      .alpha_wr_en(alpha_wr_en),
      .alpha_wr_addr(alpha_wr_addr),
      .alpha_wr_data(alpha_wr_data),
      .busy(busy), .done(done), .err(err)
   );

   function automatic avec_t mix(avec_t p, bvec_t b);
      avec_t r;
      for (int s = 0; s < ST; s++) r[s] = p[s] ^ b[s % OS];
      return r;
   endfunction

   function automatic avec_t init_vec();
      avec_t r;
      for (int s = 0; s < ST; s++)
         r[s] = (s == 0) ? 32'h0000_0000 : 32'hC61C_4000;
      return r;
   endfunction

   function automatic bvec_t rand_bm();
      bvec_t r;
      for (int o = 0; o < OS; o++) r[o] = $urandom;
      return r;
   endfunction

   int checks = 0;
   int errors = 0;

   function automatic void chk(string nm, logic [255:0] act,
                               logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Stub element; not reset, so abandoned work still returns
   int    lat = 2;
   bit    inject = 1'b0;
   avec_t stub_q = '0;
   int    stub_cnt = 0;
   bit    stub_busy = 1'b0;

   always @(posedge clk) begin
      ae_out_valid <= 1'b0;
      if (inject) begin
         ae_out_valid    <= 1'b1;
         ae_alpha_metric <= '1;
      end else if (ae_in_valid) begin
         stub_busy <= 1'b1;
         stub_cnt  <= lat;
         stub_q    <= mix(ae_previous_alpha, ae_branch_metric);
      end else if (stub_busy) begin
         if (stub_cnt <= 1) begin
            ae_out_valid    <= 1'b1;
            ae_alpha_metric <= stub_q;
            stub_busy       <= 1'b0;
         end else begin
            stub_cnt <= stub_cnt - 1;
         end
      end
   end

   // Scoreboards: expected writes and expected element issues
   typedef struct packed {
      logic [AW-1:0] addr;
      avec_t         data;
   } wr_t;
   typedef struct packed {
      bvec_t bm;
      avec_t prev;
   } is_t;

   wr_t   wr_q[$];
   is_t   is_q[$];
   avec_t m_prev = '0;
   int    m_k = 0;
   int    wr_cnt = 0;
   int    done_cnt = 0;
   int    iv_cnt = 0;
   bit    outstanding = 1'b0;

   always @(negedge clk) begin
      wr_t we;
      is_t ie;
      if (reset) begin
         outstanding = 1'b0;
         chk("reset_outputs", 256'({bm_ready, ae_in_valid,
             alpha_wr_en, busy, done, err,
             |ae_branch_metric, |ae_previous_alpha,
             |alpha_wr_addr, |alpha_wr_data}), 256'(0));
      end else begin
         if (alpha_wr_en) begin
            wr_cnt++;
            if (wr_q.size() == 0) begin
               chk("unexpected_write", 256'(1), 256'(0));
            end else begin
               we = wr_q.pop_front();
               chk("wr_addr", 256'(alpha_wr_addr), 256'(we.addr));
               chk("wr_data", 256'(alpha_wr_data), 256'(we.data));
            end
         end
         if (ae_in_valid) begin
            iv_cnt++;
            chk("single_outstanding", 256'(outstanding), 256'(0));
            outstanding = 1'b1;
            if (is_q.size() == 0) begin
               chk("unexpected_issue", 256'(1), 256'(0));
            end else begin
               ie = is_q.pop_front();
               chk("issue_bm", 256'(ae_branch_metric), 256'(ie.bm));
               chk("issue_prev", 256'(ae_previous_alpha),
                   256'(ie.prev));
            end
         end else begin
            chk("idle_ae_zero", 256'({ae_branch_metric,
                ae_previous_alpha}), 256'(0));
         end
         if (ae_out_valid) outstanding = 1'b0;
         if (done) done_cnt++;
         if (bm_valid && bm_ready) begin
            is_q.push_back('{bm_data, m_prev});
            m_prev = mix(m_prev, bm_data);
            m_k++;
            wr_q.push_back('{AW'(m_k), m_prev});
         end
      end
   end

   task automatic arm_and_start();
      @(posedge clk); #1;
      wr_q.push_back('{'0, init_vec()});
      m_prev = init_vec();
      m_k = 0;
      start = 1'b1;
      bm_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_block(input int l, input int hold,
                            input bit restart, input bit zb,
                            output int nw, output int nd,
                            output int ni);
      int w0, d0, i0;
      bit fin;
      lat = l;
      w0 = wr_cnt; d0 = done_cnt; i0 = iv_cnt;
      arm_and_start();
      if (hold > 0) begin
         fin = 1'b0;
         for (int c = 0; c < 20 && !fin; c++) begin
            @(negedge clk); #1;
            if (bm_ready) fin = 1'b1;
         end
         chk("hold_reach_issue", 256'(fin), 256'(1));
         for (int c = 0; c < hold; c++) begin
            @(negedge clk); #1;
            chk("hold_ready", 256'(bm_ready), 256'(1));
            chk("hold_no_issue", 256'(iv_cnt - i0), 256'(0));
            chk("hold_one_write", 256'(wr_cnt - w0), 256'(1));
         end
      end
      fin = 1'b0;
      for (int c = 0; c < 2000 && !fin; c++) begin
         @(posedge clk); #1;
         bm_valid = 1'b1;
         bm_data  = zb ? '0 : rand_bm();
         start    = restart && (c == 6);
         if (done_cnt > d0) fin = 1'b1;
      end
      start = 1'b0;
      bm_valid = 1'b0;
      bm_data = '0;
      chk("block_done_timeout", 256'(fin), 256'(1));
      repeat (l + 6) @(posedge clk);
      #1;
      nw = wr_cnt - w0;
      nd = done_cnt - d0;
      ni = iv_cnt - i0;
   endtask

   typedef struct {
      int lat;
      int hold;
      bit restart;
      bit zero_bm;
      int exp_wr;
      int exp_done;
      int exp_iv;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int nw, nd, ni, w0;
      bit fin;

      tbl[0] = '{2, 0,  1'b0, 1'b1, BL + 1, 1, BL};
      tbl[1] = '{1, 0,  1'b0, 1'b0, BL + 1, 1, BL};
      tbl[2] = '{3, 0,  1'b0, 1'b0, BL + 1, 1, BL};
      tbl[3] = '{7, 0,  1'b0, 1'b0, BL + 1, 1, BL};
      tbl[4] = '{2, 10, 1'b0, 1'b0, BL + 1, 1, BL};
      tbl[5] = '{2, 0,  1'b1, 1'b0, BL + 1, 1, BL};

      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk); #1;
      chk("idle_busy", 256'(busy), 256'(0));
      chk("idle_err", 256'(err), 256'(0));

      for (int i = 0; i < 6; i++) begin
         run_block(tbl[i].lat, tbl[i].hold, tbl[i].restart,
                   tbl[i].zero_bm, nw, nd, ni);
         chk("writes", 256'(nw), 256'(tbl[i].exp_wr));
         chk("done_pulses", 256'(nd), 256'(tbl[i].exp_done));
         chk("issues", 256'(ni), 256'(tbl[i].exp_iv));
         chk("err_clean", 256'(err), 256'(0));
         chk("sb_drained", 256'(wr_q.size()), 256'(0));
      end

      // Reset while waiting on the element, then a late result
      lat = 7;
      arm_and_start();
      bm_valid = 1'b1;
      bm_data = rand_bm();
      fin = 1'b0;
      for (int c = 0; c < 30 && !fin; c++) begin
         @(negedge clk); #1;
         if (ae_in_valid) fin = 1'b1;
      end
      chk("wait_reach", 256'(fin), 256'(1));
      @(posedge clk); #1;
      reset = 1'b1;
      bm_valid = 1'b0;
      wr_q.delete();
      is_q.delete();
      w0 = wr_cnt;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      fin = 1'b0;
      for (int c = 0; c < 40 && !fin; c++) begin
         @(negedge clk); #1;
         if (ae_out_valid) fin = 1'b1;
      end
      chk("late_valid_seen", 256'(fin), 256'(1));
      @(negedge clk); #1;
      chk("err_after_stray", 256'(err), 256'(1));
      chk("no_write_stray", 256'(wr_cnt - w0), 256'(0));
      chk("idle_after_reset", 256'(busy), 256'(0));

      run_block(2, 0, 1'b0, 1'b0, nw, nd, ni);
      chk("post_rst_writes", 256'(nw), 256'(BL + 1));
      chk("post_rst_done", 256'(nd), 256'(1));
      chk("err_sticky", 256'(err), 256'(1));

      // Clear err, then a stray result while idle
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk); #1;
      chk("err_cleared", 256'(err), 256'(0));
      w0 = wr_cnt;
      @(posedge clk); #1 inject = 1'b1;
      @(posedge clk); #1 inject = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("err_idle_stray", 256'(err), 256'(1));
      chk("no_write_idle", 256'(wr_cnt - w0), 256'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alpha_sequencer.md
ALPHA_SEQUENCER -- requirements
Module: alpha_sequencer

Interface
REQ-001 Parameter BITS, default 32: width of one metric word (IEEE-754 single bit pattern when PRECISION="SINGLE").
REQ-002 Parameter PRECISION, default "SINGLE": number format; only "SINGLE" is required.
REQ-003 Parameter STATES, default 4: trellis states per alpha vector.
REQ-004 Parameter OUTPUT_SYMBOLS, default 4: branch metrics per trellis step.
REQ-005 Parameter BLOCK_LEN, default 64: trellis steps per block, range 1..4096.
REQ-006 Port clk, input, 1: single clock, all logic on rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port start, input, 1: one-cycle request to process one block.
REQ-009 Port bm_valid / bm_ready, input / output, 1 each: branch-metric handshake; transfer when both are high.
REQ-010 Port bm_data, input, BITS x OUTPUT_SYMBOLS: branch metrics for the current step.
REQ-011 Port ae_in_valid, output, 1: issue strobe to alpha_element in_valid.
REQ-012 Port ae_branch_metric, output, BITS x OUTPUT_SYMBOLS: drives alpha_element branch_metric.
REQ-013 Port ae_previous_alpha, output, BITS x STATES: drives alpha_element previousAlpha.
REQ-014 Port ae_out_valid, input, 1: alpha_element out_valid.
REQ-015 Port ae_alpha_metric, input, BITS x STATES: alpha_element AlphaMetric.
REQ-016 Port alpha_wr_en, output, 1: write strobe to alpha storage.
REQ-017 Port alpha_wr_addr, output, $clog2(BLOCK_LEN+1): alpha storage index.
REQ-018 Port alpha_wr_data, output, BITS x STATES: alpha vector written.
REQ-019 Ports busy, done, err, output, 1 each: block active; one-cycle completion pulse; sticky protocol error.

Function
REQ-020 FSM states SHALL be IDLE, INIT, ISSUE, WAIT, DONE.
REQ-021 IDLE: start SHALL move to INIT; busy SHALL be low only in IDLE.
REQ-022 INIT (one cycle): write init vector to addr 0; state 0 = 32'h0000_0000 (0.0), all other states = 32'hC61C_4000 (-10000.0); load the same vector into prev register; step counter k=0; go ISSUE.
REQ-023 ISSUE: bm_ready SHALL be high; on bm_valid, drive ae_in_valid high for exactly one cycle with ae_branch_metric=bm_data and ae_previous_alpha=prev; go WAIT.
REQ-024 ae_branch_metric and ae_previous_alpha SHALL be registered and SHALL be zero whenever ae_in_valid is low.
REQ-025 WAIT: bm_ready low; on ae_out_valid, capture ae_alpha_metric into prev, write it at addr k+1 in the same cycle the capture is registered (alpha_wr_en one cycle later than ae_out_valid), increment k.
REQ-026 After a WAIT capture: if k+1 == BLOCK_LEN go DONE, else go ISSUE.
REQ-027 DONE (one cycle): done SHALL pulse high; go IDLE.
REQ-028 Exactly one outstanding issue SHALL exist; no second ae_in_valid before the matching ae_out_valid.
REQ-029 Total writes per block SHALL be BLOCK_LEN+1, addresses 0..BLOCK_LEN in increasing order, no gaps.
REQ-030 start while busy SHALL be ignored.
REQ-031 ae_out_valid outside WAIT SHALL be ignored for data and SHALL set err; err clears only on reset.
REQ-032 Sequencer latency SHALL not depend on alpha_element latency; any latency >=1 cycle is supported.
REQ-033 No arithmetic on metric values; words pass through bit-exact.

Reset
REQ-034 Reset SHALL force IDLE, k=0, prev=0 and every output (bm_ready, ae_in_valid, ae_branch_metric, ae_previous_alpha, alpha_wr_en, alpha_wr_addr, alpha_wr_data, busy, done, err) to 0.
REQ-035 Reset mid-block SHALL abandon the block; a late ae_out_valid after reset release SHALL set err.

Structure
REQ-036 Shared package SHALL hold the FSM state typedef, ALPHA_INIT_ZERO and ALPHA_INIT_NEG constants.
REQ-037 No sub-module is required; alpha_element is instantiated by the parent, not inside this block.

Verification
REQ-038 Stub element (2-cycle delay, AlphaMetric=previousAlpha), BLOCK_LEN=4, bm always valid -> 5 writes, addrs 0..4, all data {0.0,-10000.0,-10000.0,-10000.0}, done one pulse, err=0.
REQ-039 Real alpha_element, BLOCK_LEN=1, bm={1.0,2.0,3.0,4.0} -> write addr 0 init vector, addr 1 equals behavioural model output for prev=init.
REQ-040 bm_valid withheld 10 cycles in ISSUE -> bm_ready held high, no ae_in_valid, no write until bm_valid.
REQ-041 start pulsed again during block -> ignored; still exactly BLOCK_LEN+1 writes and one done.
REQ-042 reset asserted in WAIT, stub then returns ae_out_valid -> outputs 0 during reset, err=1 after stray valid, next start runs clean block.
REQ-043 Stub latency swept 1, 3, 7 cycles -> identical write sequence; never two ae_in_valid without intervening ae_out_valid.
